dom_share_gen: RTL and testbench

DOM_SHARE_GEN -- requirements
Module: dom_share_gen

---
 rtl/dom_share_gen_pkg.sv | 17 +
 rtl/dom_share_gen_lfsr32.sv | 19 +
 rtl/dom_share_gen.sv | 76 +++++++
 tb/tb_dom_share_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dom_share_gen_pkg.sv
// dom_share_gen_pkg: FSM encoding, in_vec field layout and LFSR polynomial
// shared by the DOM share generator and its LFSR.
package dom_share_gen_pkg;
   typedef enum logic [1:0] {IDLE, GEN, DRIVE, PRECHARGE} state_e;
   localparam int IN_SIZE = 14;
   localparam int A_LSB = 10;
   localparam int B_LSB = 6;
   localparam int R_LSB = 0;
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   // Only r[11:0] carries randomness into the vector; shares are listed MSB first.
   function automatic logic [IN_SIZE-1:0] share_vec(input logic a, input logic b, input logic [31:0] r);
      share_vec = '0;
      share_vec[A_LSB+:4] = {r[0], r[1], r[2], a ^ (^r[2:0])};
      share_vec[B_LSB+:4] = {r[3], r[4], r[5], b ^ (^r[5:3])};
      share_vec[R_LSB+:6] = {r[6], r[7], r[8], r[9], r[10], r[11]};
   endfunction
endpackage

// File: rtl/dom_share_gen_lfsr32.sv
// lfsr32: 32-bit Galois LFSR, x^32+x^22+x^2+x+1, with zero-safe seed load.
module lfsr32
   import dom_share_gen_pkg::*;
#(
   parameter logic [31:0] INIT = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   output logic [31:0] state
);
   logic [31:0] state_d;
   always_comb
      state_d = load ? ((seed == '0) ? 32'h1 : seed) : ((state >> 1) ^ (state[0] ? LFSR_POLY : '0));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= INIT;
      else state <= state_d;
endmodule

// File: rtl/dom_share_gen.sv
// dom_share_gen: splits a and b into 4 shares each plus 6 fresh random bits,
// holds the masked vector for HOLD_CYCLES cycles, then precharges to zero.
module dom_share_gen
   import dom_share_gen_pkg::*;
#(
   parameter int          HOLD_CYCLES = 16,
   parameter logic [31:0] LFSR_INIT   = 32'hACE1_0001
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               a,
   input  logic               b,
   input  logic               mask_en,
   input  logic               seed_load,
   input  logic [31:0]        seed,
   output logic [IN_SIZE-1:0] in_vec,
   output logic               valid,
   output logic               ready,
   output logic               done
);
   state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [IN_SIZE-1:0] vec_q, vec_d;
   logic [31:0] lfsr;
   logic a_q, a_d, b_q, b_d, m_q, m_d, armed_q, valid_q, valid_d, done_q, done_d;
   logic idle, accept, hold, last;
   assign idle   = state_q == IDLE;
   assign accept = idle && armed_q && start && !seed_load;
   assign last   = state_q == DRIVE && cnt_q == '0;
   assign hold   = state_q == DRIVE && !last;
   lfsr32 #(.INIT(LFSR_INIT)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (idle && seed_load),
      .seed  (seed),
      .state (lfsr)
   );
   always_comb begin
      state_d = accept ? GEN : (state_q == GEN) ? DRIVE : last ? PRECHARGE : (state_q == PRECHARGE) ? IDLE : state_q;
      cnt_d   = (state_q == GEN) ? 8'(HOLD_CYCLES - 1) : hold ? cnt_q - 8'd1 : '0;
      a_d     = accept ? a : a_q;
      b_d     = accept ? b : b_q;
      m_d     = accept ? mask_en : m_q;
      vec_d   = (state_q == GEN) ? share_vec(a_q, b_q, m_q ? lfsr : '0) : hold ? vec_q : '0;
      valid_d = state_q == GEN || hold;
      done_d  = last;
   end
   // armed_q delays start acceptance by one edge after reset release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         m_q     <= 1'b0;
         armed_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         armed_q <= 1'b1;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   assign in_vec = vec_q;
   assign valid  = valid_q;
   assign done   = done_q;
   assign ready  = idle;
endmodule

// File: tb/tb_dom_share_gen.sv
// tb_dom_share_gen: table vectors, latency/abort sequences and seeded random
// runs checked against a scoreboard of expected masked vectors.
module tb_dom_share_gen;
   localparam int H = 16;
   logic clk = 0, rst_n = 1, start = 0, a = 0, b = 0, mask_en = 0, seed_load = 0;
   logic [31:0] seed = 0;
   logic [13:0] in_vec;
   logic valid, ready, done;
   typedef struct {logic [13:0] v; logic a; logic b;} exp_t;
   typedef struct {logic a; logic b; logic [13:0] v;} vec_t;
   exp_t q[$];
   exp_t cur;
   int checks = 0, errors = 0, dones = 0, runs = 0, vcnt = 0;
   logic pv = 0;

   dom_share_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .mask_en(mask_en),
      .seed_load(seed_load), .seed(seed), .in_vec(in_vec), .valid(valid), .ready(ready), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] nxt(logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [13:0] ref_vec(logic a_, logic b_, logic [11:0] r);
      logic [3:0] as, bs;
      logic [5:0] rs;
      as = {r[0], r[1], r[2], a_ ^ r[0] ^ r[1] ^ r[2]};
      bs = {r[3], r[4], r[5], b_ ^ r[3] ^ r[4] ^ r[5]};
      rs = {r[6], r[7], r[8], r[9], r[10], r[11]};
      return {as, bs, rs};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 0;
         vcnt = 0;
      end else begin
         chk("lfsr_nonzero", 32'(dut.u_lfsr.state != 0), 1);
         if (valid && !pv) begin
            chk("unexpected_run", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               cur = q.pop_front();
               chk("vec", 32'(in_vec), 32'(cur.v));
               chk("a_parity", 32'(^in_vec[13:10]), 32'(cur.a));
               chk("b_parity", 32'(^in_vec[9:6]), 32'(cur.b));
            end
         end else if (valid) chk("hold", 32'(in_vec), 32'(cur.v));
         else begin
            chk("idle_zero", 32'(in_vec), 0);
            if (pv) chk("hold_len", vcnt, H);
         end
         vcnt = valid ? vcnt + 1 : 0;
         if (done) dones++;
         pv = valid;
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ready_timeout", 32'(ready), 1);
   endtask

   task automatic run(logic a_, logic b_, logic m_, logic [13:0] e);
      int t = 0;
      wait_ready();
      a = a_; b = b_; mask_en = m_; start = 1;
      q.push_back('{e, a_, b_});
      runs++;
      @(negedge clk);
      start = 0;
      while (done !== 1'b1 && t < H + 10) begin
         @(negedge clk);
         t++;
      end
      chk("done_timeout", 32'(done), 1);
      @(negedge clk);
   endtask

   task automatic srun(logic [31:0] s, logic a_, logic b_, logic m_);
      logic [31:0] st, n;
      wait_ready();
      seed = s; seed_load = 1;
      @(negedge clk);
      seed_load = 0;
      st = (s == 0) ? 32'h1 : s;
      chk("seed_state", dut.u_lfsr.state, st);
      n = m_ ? nxt(st) : 32'h0;
      run(a_, b_, m_, ref_vec(a_, b_, n[11:0]));
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      tbl = '{'{1'b1, 1'b1, 14'h0440}, '{1'b0, 1'b1, 14'h0040}, '{1'b1, 1'b0, 14'h0400}, '{1'b0, 1'b0, 14'h0000}};
      #2 rst_n = 0;
      #1;
      chk("rst_in_vec", 32'(in_vec), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_lfsr", dut.u_lfsr.state, 32'hACE1_0001);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1; start = 1; a = 1; b = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      @(negedge clk);
      chk("first_edge_ignored", 32'(valid), 0);

      for (int i = 0; i < 4; i++) run(tbl[i].a, tbl[i].b, 1'b0, tbl[i].v);

      wait_ready();
      a = 1; b = 1; mask_en = 0; start = 1;
      q.push_back('{14'h0440, 1'b1, 1'b1});
      runs++;
      @(negedge clk);
      start = 0;
      chk("lat_gen_valid", 32'(valid), 0);
      chk("lat_gen_ready", 32'(ready), 0);
      @(negedge clk);
      chk("lat_first_valid", 32'(valid), 1);
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (H - 2) @(negedge clk);
      chk("lat_last_valid", 32'(valid), 1);
      chk("lat_no_early_done", 32'(done), 0);
      @(negedge clk);
      chk("lat_done", 32'(done), 1);
      chk("lat_pre_valid", 32'(valid), 0);
      chk("lat_pre_ready", 32'(ready), 0);
      start = 1;
      @(negedge clk);
      start = 0;
      chk("lat_done_single", 32'(done), 0);
      chk("lat_ready", 32'(ready), 1);
      @(negedge clk);
      chk("no_queued_start", 32'(valid), 0);

      srun(32'h1, 1'b1, 1'b0, 1'b1);
      srun(32'h0, 1'b0, 1'b1, 1'b1);

      wait_ready();
      seed = 32'h1234_5678; seed_load = 1; start = 1;
      @(negedge clk);
      seed_load = 0; start = 0;
      chk("load_wins_state", dut.u_lfsr.state, 32'h1234_5678);
      @(negedge clk);
      chk("load_wins_valid", 32'(valid), 0);
      chk("load_wins_ready", 32'(ready), 1);

      wait_ready();
      a = 0; b = 1; mask_en = 0; start = 1;
      q.push_back('{14'h0040, 1'b0, 1'b1});
      @(negedge clk);
      start = 0;
      @(negedge clk);
      repeat (4) @(negedge clk);
      chk("abort_pre_valid", 32'(valid), 1);
      #2 rst_n = 0;
      #1;
      chk("abort_in_vec", 32'(in_vec), 0);
      chk("abort_valid", 32'(valid), 0);
      chk("abort_ready", 32'(ready), 1);
      chk("abort_done", 32'(done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      run(1'b0, 1'b1, 1'b0, 14'h0040);

      for (int i = 0; i < 3000; i++)
         srun($urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(3) != 0));

      wait_ready();
      chk("done_count", dones, runs);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
